// File: rtl/revaluate_pkg.sv
// -----------------------------------------------------------------------------
// revaluate_pkg
// Shared definitions for the batched chi ("revaluate") engine:
//   SLICE_W / ROW_W  - slice width (25) and row width (5)
//   state_e          - controller state encoding (IDLE, RUN, DONE)
//   chi_slice()      - 25-bit chi of one slice
// -----------------------------------------------------------------------------
package revaluate_pkg;

  localparam int SLICE_W = 25;
  localparam int ROW_W   = 5;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  // r[5y+x] = a[5y+x] ^ (~a[5y+(x+1)%5] & a[5y+(x+2)%5]); rows are independent.
  function automatic logic [SLICE_W-1:0] chi_slice(input logic [SLICE_W-1:0] a);
    logic [SLICE_W-1:0] r;
    r = '0;
    for (int y = 0; y < ROW_W; y++) begin
      for (int x = 0; x < ROW_W; x++) begin
        r[ROW_W*y + x] = a[ROW_W*y + x] ^
                         (~a[ROW_W*y + ((x + 1) % ROW_W)] & a[ROW_W*y + ((x + 2) % ROW_W)]);
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/revaluate_lane.sv
// -----------------------------------------------------------------------------
// revaluate_lane
// One combinational chi unit for a single 25-bit slice, with pass-through.
// Ports:
//   slice_i  [24:0]  input slice
//   bypass_i         1 = slice_o copies slice_i
//   slice_o  [24:0]  chi(slice_i) or slice_i
// -----------------------------------------------------------------------------
module revaluate_lane
  import revaluate_pkg::*;
(
  input  logic [SLICE_W-1:0] slice_i,
  input  logic               bypass_i,
  output logic [SLICE_W-1:0] slice_o
);

  assign slice_o = bypass_i ? slice_i : chi_slice(slice_i);

endmodule

// File: rtl/revaluate_batch_engine.sv
// -----------------------------------------------------------------------------
// revaluate_batch_engine
// Applies chi to a NUM_SLICES x 25-bit state using LANES chi units, one batch
// of LANES slices per cycle, under a start/done handshake. Optional bypass
// copies the state unchanged.
//
// state | meaning
// ------+-----------------------------------------------------------
// IDLE  | waiting for start; out held stable
// RUN   | one batch per cycle written into out, cnt = batch index
// DONE  | out complete; done pulses for this single cycle
//
// Ports:
//   clk_i          clock, rising edge
//   rst_ni         asynchronous active-low reset
//   start_i        request, sampled only in IDLE
//   bypass_i       captured with start_i; 1 = out copies in
//   in_i           state, slice s at [25s+24:25s]
//   out_o          result register, same layout
//   busy_o         high whenever not IDLE
//   done_o         one-cycle completion pulse
//   start_err_o    (REVALUATE_START_ERR_EN only) pulses one cycle after any
//                  cycle with start_i high while busy
//
// Build option: define REVALUATE_START_ERR_EN to add start_err_o.
// -----------------------------------------------------------------------------
module revaluate_batch_engine
  import revaluate_pkg::*;
#(
  parameter int NUM_SLICES = 64,
  parameter int LANES      = 8
) (
  input  logic                          clk_i,
  input  logic                          rst_ni,
  input  logic                          start_i,
  input  logic                          bypass_i,
  input  logic [NUM_SLICES*SLICE_W-1:0] in_i,
  output logic [NUM_SLICES*SLICE_W-1:0] out_o,
  output logic                          busy_o,
`ifdef REVALUATE_START_ERR_EN
  output logic                          start_err_o,
`endif
  output logic                          done_o
);

  localparam int STATE_W   = NUM_SLICES * SLICE_W;
  localparam int BATCH_W   = LANES * SLICE_W;
  localparam int NUM_BATCH = NUM_SLICES / LANES;
  localparam int CNT_W     = (NUM_BATCH > 1) ? $clog2(NUM_BATCH) : 1;

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [STATE_W-1:0] buf_q, buf_d;
  logic [STATE_W-1:0] out_q, out_d;
  logic               bypass_q, bypass_d;

  logic [BATCH_W-1:0] batch_in;
  logic [BATCH_W-1:0] batch_res;
  logic [31:0]        batch_base;
  logic               last_batch;

  // Batch select: the current batch of the captured state feeds all lanes.
  assign batch_base = 32'(cnt_q) * 32'(BATCH_W);
  assign batch_in   = buf_q[batch_base +: BATCH_W];
  assign last_batch = (cnt_q == CNT_W'(NUM_BATCH - 1));

  for (genvar l = 0; l < LANES; l++) begin : g_lane
    revaluate_lane u_lane (
      .slice_i  (batch_in[l*SLICE_W +: SLICE_W]),
      .bypass_i (bypass_q),
      .slice_o  (batch_res[l*SLICE_W +: SLICE_W])
    );
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    buf_d    = buf_q;
    out_d    = out_q;
    bypass_d = bypass_q;
    case (state_q)
      IDLE: begin
        if (start_i) begin
          buf_d    = in_i;
          bypass_d = bypass_i;
          cnt_d    = '0;
          state_d  = RUN;
        end
      end
      RUN: begin
        // Slices of later batches keep their previous values until written.
        out_d[batch_base +: BATCH_W] = batch_res;
        if (last_batch) begin
          cnt_d   = '0;
          state_d = DONE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      buf_q    <= '0;
      out_q    <= '0;
      bypass_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      buf_q    <= buf_d;
      out_q    <= out_d;
      bypass_q <= bypass_d;
    end
  end

  assign out_o  = out_q;
  assign busy_o = (state_q != IDLE);
  assign done_o = (state_q == DONE);

`ifdef REVALUATE_START_ERR_EN
  logic start_err_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      start_err_q <= 1'b0;
    end else begin
      start_err_q <= start_i & busy_o;
    end
  end

  assign start_err_o = start_err_q;
`endif

endmodule

// File: tb/tb_revaluate_batch_engine.sv
// -----------------------------------------------------------------------------
// tb_revaluate_batch_engine
// Three engine instances (LANES = 8, 1, 64; NUM_SLICES = 64) share clock,
// reset, in and bypass; each has its own start. A vector table drives all
// three; hand-written sequences cover busy rejection, mid-run reset and
// back-to-back operation on the LANES=8 instance.
// -----------------------------------------------------------------------------
module tb_revaluate_batch_engine;

  localparam int NS = 64;
  localparam int SW = 25;
  localparam int NW = NS * SW;

  logic          clk;
  logic          rst_n;
  logic          bypass;
  logic [NW-1:0] in_v;
  logic          start8, start1, start64;
  logic [NW-1:0] out8, out1, out64;
  logic          busy8, busy1, busy64;
  logic          done8, done1, done64;
`ifdef REVALUATE_START_ERR_EN
  logic          start_err8, start_err1, start_err64;
`endif

  int n_chk  = 0;
  int n_fail = 0;

  revaluate_batch_engine #(.NUM_SLICES(NS), .LANES(8)) u_dut8 (
    .clk_i (clk), .rst_ni (rst_n), .start_i (start8), .bypass_i (bypass),
    .in_i (in_v), .out_o (out8), .busy_o (busy8),
`ifdef REVALUATE_START_ERR_EN
    .start_err_o (start_err8),
`endif
    .done_o (done8)
  );

  revaluate_batch_engine #(.NUM_SLICES(NS), .LANES(1)) u_dut1 (
    .clk_i (clk), .rst_ni (rst_n), .start_i (start1), .bypass_i (bypass),
    .in_i (in_v), .out_o (out1), .busy_o (busy1),
`ifdef REVALUATE_START_ERR_EN
    .start_err_o (start_err1),
`endif
    .done_o (done1)
  );

  revaluate_batch_engine #(.NUM_SLICES(NS), .LANES(64)) u_dut64 (
    .clk_i (clk), .rst_ni (rst_n), .start_i (start64), .bypass_i (bypass),
    .in_i (in_v), .out_o (out64), .busy_o (busy64),
`ifdef REVALUATE_START_ERR_EN
    .start_err_o (start_err64),
`endif
    .done_o (done64)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  // Row-rotation formulation of chi, used as the reference.
  function automatic logic [NW-1:0] model_chi(input logic [NW-1:0] st);
    logic [NW-1:0] r;
    logic [4:0] row, rot1, rot2;
    r = '0;
    for (int s = 0; s < NS; s++) begin
      for (int y = 0; y < 5; y++) begin
        row  = st[s*SW + y*5 +: 5];
        rot1 = {row[0], row[4:1]};
        rot2 = {row[1:0], row[4:2]};
        r[s*SW + y*5 +: 5] = row ^ (~rot1 & rot2);
      end
    end
    return r;
  endfunction

  function automatic logic [NW-1:0] rand_state();
    logic [NW-1:0] v;
    for (int s = 0; s < NS; s++) v[s*SW +: SW] = 25'($urandom);
    return v;
  endfunction

  function automatic logic [NW-1:0] fill_state(input logic [SW-1:0] sl);
    logic [NW-1:0] v;
    for (int s = 0; s < NS; s++) v[s*SW +: SW] = sl;
    return v;
  endfunction

  function automatic logic [NW-1:0] get_out(input int w);
    case (w)
      1:       return out1;
      64:      return out64;
      default: return out8;
    endcase
  endfunction

  function automatic logic get_done(input int w);
    case (w)
      1:       return done1;
      64:      return done64;
      default: return done8;
    endcase
  endfunction

  function automatic logic get_busy(input int w);
    case (w)
      1:       return busy1;
      64:      return busy64;
      default: return busy8;
    endcase
  endfunction

  task automatic set_start(input int w, input logic v);
    case (w)
      1:       start1  = v;
      64:      start64 = v;
      default: start8  = v;
    endcase
  endtask

  task automatic check_int(input string nm, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic check_vec(input string nm, input logic [NW-1:0] act, input logic [NW-1:0] exp);
    int first;
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      first = 0;
      for (int s = NS - 1; s >= 0; s--) if (act[s*SW +: SW] !== exp[s*SW +: SW]) first = s;
      $display("FAIL %s: slice %0d got %h expected %h", nm, first,
               act[first*SW +: SW], exp[first*SW +: SW]);
    end
  endtask

  // Launches one operation on instance w; returns cycles from the start edge
  // to the first cycle with done high (-1 if the bound expired).
  task automatic run_op(input int w, input logic [NW-1:0] v, input logic bp, output int lat);
    @(posedge clk); #1;
    in_v   = v;
    bypass = bp;
    set_start(w, 1'b1);
    @(posedge clk); #1;
    set_start(w, 1'b0);
    lat = -1;
    for (int c = 1; c <= 100; c++) begin
      @(posedge clk); #1;
      if (get_done(w)) begin
        lat = c;
        break;
      end
    end
  endtask

  typedef struct {
    string         name;
    logic [NW-1:0] in_v;
    logic          bp;
    logic [NW-1:0] exp_v;
  } vec_t;

  vec_t vecs[6];

  initial begin
    int            lat;
    int            nd;
    int            ws[3];
    int            lats[3];
    logic [NW-1:0] held;
    logic [NW-1:0] t;

    ws   = '{8, 1, 64};
    lats = '{8, 64, 1};

    t = fill_state(25'h0000001);
    t[5*SW +: SW] = 25'h0000002;
    vecs[0].name = "single_bit"; vecs[0].in_v = t; vecs[0].bp = 1'b0;
    t = fill_state(25'h0000009);
    t[5*SW +: SW] = 25'h0000012;
    vecs[0].exp_v = t;

    vecs[1].name = "all_ones"; vecs[1].in_v = fill_state(25'h1FFFFFF);
    vecs[1].bp = 1'b0;         vecs[1].exp_v = fill_state(25'h1FFFFFF);

    vecs[2].name = "all_zero"; vecs[2].in_v = '0;
    vecs[2].bp = 1'b0;         vecs[2].exp_v = '0;

    vecs[3].name = "bypass"; vecs[3].in_v = rand_state();
    vecs[3].bp = 1'b1;       vecs[3].exp_v = vecs[3].in_v;

    vecs[4].name = "rand_a"; vecs[4].in_v = rand_state();
    vecs[4].bp = 1'b0;       vecs[4].exp_v = model_chi(vecs[4].in_v);

    vecs[5].name = "rand_b"; vecs[5].in_v = rand_state();
    vecs[5].bp = 1'b0;       vecs[5].exp_v = model_chi(vecs[5].in_v);

    rst_n = 1'b0; bypass = 1'b0; in_v = '0;
    start8 = 1'b0; start1 = 1'b0; start64 = 1'b0;
    #22;
    for (int k = 0; k < 3; k++) begin
      check_vec($sformatf("reset_out_l%0d", ws[k]), get_out(ws[k]), '0);
      check_int($sformatf("reset_busy_l%0d", ws[k]), int'(get_busy(ws[k])), 0);
      check_int($sformatf("reset_done_l%0d", ws[k]), int'(get_done(ws[k])), 0);
    end
    #5 rst_n = 1'b1;

    // Vector table on every lane configuration.
    for (int i = 0; i < 6; i++) begin
      for (int k = 0; k < 3; k++) begin
        run_op(ws[k], vecs[i].in_v, vecs[i].bp, lat);
        check_int($sformatf("%s_lat_l%0d", vecs[i].name, ws[k]), lat, lats[k]);
        check_vec($sformatf("%s_out_l%0d", vecs[i].name, ws[k]), get_out(ws[k]), vecs[i].exp_v);
        @(posedge clk); #1;
        check_int($sformatf("%s_done1cyc_l%0d", vecs[i].name, ws[k]), int'(get_done(ws[k])), 0);
        check_int($sformatf("%s_idle_l%0d", vecs[i].name, ws[k]), int'(get_busy(ws[k])), 0);
      end
      // out must hold while idle regardless of in.
      held = out8;
      in_v = ~in_v;
      bypass = ~bypass;
      repeat (3) @(posedge clk);
      #1;
      check_vec($sformatf("%s_hold", vecs[i].name), out8, held);
    end

    // Busy rejection: extra starts at cycles 3 and 8 with different in/bypass.
    @(posedge clk); #1;
    in_v = vecs[4].in_v; bypass = 1'b0; start8 = 1'b1;
    @(posedge clk); #1;
    start8 = 1'b0; in_v = vecs[5].in_v; bypass = 1'b1;
    nd = 0;
    for (int c = 1; c <= 12; c++) begin
      @(posedge clk); #1;
      check_int($sformatf("busyrej_done_c%0d", c), int'(done8), int'(c == 8));
      check_int($sformatf("busyrej_busy_c%0d", c), int'(busy8), int'(c <= 8));
`ifdef REVALUATE_START_ERR_EN
      check_int($sformatf("busyrej_err_c%0d", c), int'(start_err8), int'(c == 4 || c == 9));
`endif
      nd += int'(done8);
      start8 = (c == 3 || c == 8);
    end
    check_int("busyrej_ndone", nd, 1);
    check_vec("busyrej_out", out8, vecs[4].exp_v);

    // Reset during RUN, then a clean operation.
    @(posedge clk); #1;
    in_v = vecs[3].in_v; bypass = 1'b0; start8 = 1'b1;
    @(posedge clk); #1;
    start8 = 1'b0;
    repeat (4) @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    check_vec("midrst_out", out8, '0);
    check_int("midrst_busy", int'(busy8), 0);
    check_int("midrst_done", int'(done8), 0);
    check_vec("midrst_out_l64", out64, '0);
    #2 rst_n = 1'b1;
    run_op(8, vecs[5].in_v, 1'b0, lat);
    check_int("postrst_lat", lat, 8);
    check_vec("postrst_out", out8, vecs[5].exp_v);
    @(posedge clk); #1;

    // start held high for 30 cycles: done at 8, 18, 28.
    @(posedge clk); #1;
    in_v = vecs[4].in_v; bypass = 1'b0; start8 = 1'b1;
    nd = 0;
    for (int c = 0; c < 30; c++) begin
      @(posedge clk); #1;
      check_int($sformatf("b2b_done_c%0d", c), int'(done8), int'(c == 8 || c == 18 || c == 28));
      nd += int'(done8);
    end
    start8 = 1'b0;
    check_int("b2b_ndone", nd, 3);
    check_vec("b2b_out", out8, vecs[4].exp_v);
    repeat (3) @(posedge clk);
    #1;
    check_int("b2b_idle", int'(busy8), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/revaluate_batch_engine.md
Name: revaluate_batch_engine

Overview:
Parametrised successor of the encoder's chi ("revaluate") stage for the Keccak-style state (NUM_SLICES slices of 25 bits each).
- The current stage runs one instance per slice. This block instead time-multiplexes LANES chi units over the slices, one batch per cycle.
- It adds a run-time bypass mode and a busy indication.
- It sits between the permutation stage and the round-constant stage, under the same start/done handshake.

Parameters:
NUM_SLICES, 64, number of 25-bit slices in the state; must be a multiple of LANES.
LANES, 8, chi units working in parallel; legal values 1, 2, 4, 8, 16, 32, 64.

Ports:
clk  in  1  clock; rising edge.
rst  in  1  asynchronous, active-low reset.
start  in  1  request; sampled only in IDLE.
bypass  in  1  captured with start; 1 = output copies input unchanged.
in  in  NUM_SLICES*25  state; slice s occupies bits [25s+24:25s].
out  out  NUM_SLICES*25  result register, same layout as in.
busy  out  1  high whenever state != IDLE.
done  out  1  one-cycle completion pulse.

Behaviour:
- Reset (rst low, asynchronous): state=IDLE, out=0, buffer=0, batch counter=0, busy=0, done=0, bypass latch=0.
- Reset mid-operation aborts the operation: all registers return to their reset values and the partial result is discarded.
- Chi, per slice a, with bit index 5y+x (x,y in 0..4):
  - r[5y+x] = a[5y+x] ^ (~a[5y+(x+1)%5] & a[5y+(x+2)%5]).
  - Purely bitwise; no carries; no dependence between slices.
- Bypass: r = a.
- B = NUM_SLICES/LANES.
- FSM states: IDLE, RUN, DONE.
  - IDLE: on an edge where start=1, capture in into the internal buffer, latch bypass, clear the counter, go to RUN. in is not sampled again during the operation.
  - RUN: each edge computes slices cnt*LANES .. cnt*LANES+LANES-1 from the buffer and writes them into out; cnt increments. At the edge where cnt==B-1, go to DONE.
  - DONE: done=1 for exactly this one cycle, then IDLE.
- Latency: start sampled at edge E0. Batches are written at E1..EB. done is high between EB and EB+1. busy is high from E0 to EB+1.
- With the defaults this gives done 8 cycles after start. LANES=NUM_SLICES gives B=1 and done 1 cycle after start.
- out validity:
  - Slices not yet overwritten keep their previous values while RUN is in progress.
  - out is guaranteed complete and valid while done=1.
  - out is then held stable until the next accepted start.
- start while busy (RUN or DONE) is ignored: no restart and no effect on the buffer.
- start held high continuously re-triggers on the first IDLE edge after DONE, so operations run back to back with one IDLE cycle between them.
- Changing in or bypass after acceptance does not affect the running operation.

Optional Feature:
REVALUATE_START_ERR_EN
- Defined: adds output start_err (1 bit, reset 0). start_err pulses high for one cycle on the edge following any cycle with start=1 while busy=1. Operation is unaffected.
- Undefined: the port does not exist and start during busy is silently ignored.

Decomposition:
- Package revaluate_pkg holds:
  - constants SLICE_W=25 and ROW_W=5;
  - the FSM state encoding (IDLE, RUN, DONE);
  - function chi_slice(25-bit) returning the 25-bit chi result.
- Sub-module revaluate_lane: combinational, one slice in, one slice out plus bypass. It is instantiated LANES times.
- The batch mux/demux, counter and FSM live in the top module.

Test Plan:
1. Single-bit slices, bypass=0, all slices 0x0000001 except slice 5 = 0x0000002 -> after done: all slices 0x0000009, slice 5 = 0x0000012. done arrives exactly 8 cycles after the start edge and lasts 1 cycle.
2. Fixed patterns: all slices 0x1FFFFFF -> 0x1FFFFFF; all slices 0 -> 0. Random state with bypass=1 -> out==in bit-exact. Randomised state checked against a bench model of chi_slice.
3. Busy rejection: pulse start again at cycles 3 and 8 after acceptance with a different in -> result reflects only the first in. With REVALUATE_START_ERR_EN, start_err pulses twice.
4. Reset mid-operation: assert rst at cycle 4 of RUN -> out, busy and done are 0 immediately (asynchronously). A new start then completes normally.
5. Parameter sweep: LANES=1, 8, 64 with NUM_SLICES=64 -> done latency 64, 8 and 1 cycles respectively, with identical results.
6. start held high for 30 cycles (LANES=8) -> three completed operations, with done pulses at cycles 8, 18 and 28 after the first accepted start.
